ula_sequenciador: RTL and testbench

Multicycle issue/write-back controller sitting on the driving side of the combinational ALU (`ULA`). It accepts 16-bit register-register instructions over a valid/ready handshake and reads both source operands from an internal 8×16 register file. It drives `ULA` operands and opcode from registers, samples the 32-bit result, writes it back, and reports completion. It is the datapath/control half that turns the bare ALU into an executable unit.

---
 rtl/ula_pkg.sv | 34 +++
 rtl/ula_banco_reg.sv | 39 +++
 rtl/ula_sequenciador.sv | 182 ++++++++++++++++++
 tb/tb_ula_sequenciador.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU issue/write-back controller: opcodes, FSM states,
// instruction field positions and a field-extraction helper.
package ula_pkg;

    localparam int DW      = 16;
    localparam int AW      = 3;
    localparam int OPC_LSB = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_DIV = 3'b010,
        OP_MUL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_NOT = 3'b110,
        OP_XOR = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LER     = 2'd1,
        EXEC    = 2'd2,
        ESCREVE = 2'd3
    } estado_t;

    function automatic logic [AW-1:0] campo(input logic [DW-1:0] ins, input int lsb);
        return ins[lsb +: AW];
    endfunction

endpackage

// File: rtl/ula_banco_reg.sv
// 8x16 register file: one write port, two combinational operand reads and a debug read.
// Every entry clears on reset so the controller starts from a known architectural state.
module ula_banco_reg
    import ula_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] dbg_sel,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] dbg_valor
);

    logic [DW-1:0] regs_q [NREG];

    // NOTE: this array is reset entry by entry, so it maps to flops rather than a RAM
    // macro; that is intended here because reset must clear every register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1    = regs_q[raddr1];
    assign rdata2    = regs_q[raddr2];
    assign dbg_valor = regs_q[dbg_sel];

endmodule

// File: rtl/ula_sequenciador.sv
// Four-state issue/write-back controller driving an external combinational ALU.
// Define ULA_SEQ_HI_EN to keep the upper half of mul results in a HI register.
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    input  logic          carga_en,
    input  logic [2:0]    carga_end,
    input  logic [15:0]   carga_dado,
    output logic [15:0]   ula_operando1,
    output logic [15:0]   ula_operando2,
    output logic [2:0]    ula_opcode,
    input  logic [31:0]   ula_resultado,
    output logic          concluido,
    output logic [2:0]    concluido_rd,
    output logic [15:0]   concluido_valor,
    output logic          erro_div0,
    input  logic [2:0]    dbg_sel,
    output logic [15:0]   dbg_valor
`ifdef ULA_SEQ_HI_EN
    ,
    output logic [15:0]   hi_valor
`endif
);

    estado_t       state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic [15:0]   op1_q, op1_d, op2_q, op2_d;
    op_t           opc_q, opc_d;
    logic [31:0]   res_q, res_d;
    logic          div0_q, div0_d;
    logic          conc_q, conc_d, err_q, err_d;
    logic [2:0]    conc_rd_q, conc_rd_d;
    logic [15:0]   conc_val_q, conc_val_d;
`ifdef ULA_SEQ_HI_EN
    logic [15:0]   hi_q, hi_d;
`endif

    logic          we;
    logic [2:0]    waddr;
    logic [15:0]   wdata, rdata1, rdata2;
    logic [2:0]    rd;

    assign rd = campo(instr_q, RD_LSB);

    ula_banco_reg #(.NREG(NREG)) u_banco (
        .clock     (clock),
        .reset_n   (reset_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (campo(instr_q, RS1_LSB)),
        .raddr2    (campo(instr_q, RS2_LSB)),
        .dbg_sel   (dbg_sel),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .dbg_valor (dbg_valor)
    );

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opc_d       = opc_q;
        res_d       = res_q;
        div0_d      = div0_q;
        conc_d      = 1'b0;
        err_d       = 1'b0;
        conc_rd_d   = conc_rd_q;
        conc_val_d  = conc_val_q;
`ifdef ULA_SEQ_HI_EN
        hi_d        = hi_q;
`endif
        instr_ready = 1'b0;
        we          = 1'b0;
        waddr       = carga_end;
        wdata       = carga_dado;

        case (state_q)
            OCIOSO: begin
                instr_ready = 1'b1;
                we          = carga_en;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = LER;
                end
            end
            LER: begin
                op1_d   = rdata1;
                op2_d   = rdata2;
                opc_d   = op_t'(campo(instr_q, OPC_LSB));
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = ula_resultado;
                div0_d  = (opc_q == OP_DIV) && (op2_q == '0);
                state_d = ESCREVE;
            end
            ESCREVE: begin
                if (div0_q) begin
                    err_d = 1'b1;
                end else begin
                    we         = 1'b1;
                    waddr      = rd;
                    wdata      = res_q[15:0];
                    conc_d     = 1'b1;
                    conc_rd_d  = rd;
                    conc_val_d = res_q[15:0];
                end
`ifdef ULA_SEQ_HI_EN
                if (opc_q == OP_MUL) hi_d = res_q[31:16];
`endif
                state_d = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= OCIOSO;
            instr_q    <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            opc_q      <= OP_ADD;
            res_q      <= '0;
            div0_q     <= 1'b0;
            conc_q     <= 1'b0;
            err_q      <= 1'b0;
            conc_rd_q  <= '0;
            conc_val_q <= '0;
`ifdef ULA_SEQ_HI_EN
            hi_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            opc_q      <= opc_d;
            res_q      <= res_d;
            div0_q     <= div0_d;
            conc_q     <= conc_d;
            err_q      <= err_d;
            conc_rd_q  <= conc_rd_d;
            conc_val_q <= conc_val_d;
`ifdef ULA_SEQ_HI_EN
            hi_q       <= hi_d;
`endif
        end
    end

    assign ula_operando1   = op1_q;
    assign ula_operando2   = op2_q;
    assign ula_opcode      = opc_q;
    assign concluido       = conc_q;
    assign erro_div0       = err_q;
    assign concluido_rd    = conc_rd_q;
    assign concluido_valor = conc_val_q;

`ifdef ULA_SEQ_HI_EN
    assign hi_valor = hi_q;
    logic unused_bits;
    assign unused_bits = ^instr_q[3:0];
`else
    // Without HI the upper product half has nowhere to go.
    logic unused_bits;
    assign unused_bits = ^{instr_q[3:0], res_q[31:16]};
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a behavioural model of the external ALU.
module tb_ula_sequenciador;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        carga_en;
    logic [2:0]  carga_end;
    logic [15:0] carga_dado;
    logic [15:0] ula_operando1, ula_operando2;
    logic [2:0]  ula_opcode;
    logic [31:0] ula_resultado;
    logic        concluido;
    logic [2:0]  concluido_rd;
    logic [15:0] concluido_valor;
    logic        erro_div0;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_valor;
`ifdef ULA_SEQ_HI_EN
    logic [15:0] hi_valor;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ula_sequenciador dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .carga_en        (carga_en),
        .carga_end       (carga_end),
        .carga_dado      (carga_dado),
        .ula_operando1   (ula_operando1),
        .ula_operando2   (ula_operando2),
        .ula_opcode      (ula_opcode),
        .ula_resultado   (ula_resultado),
        .concluido       (concluido),
        .concluido_rd    (concluido_rd),
        .concluido_valor (concluido_valor),
        .erro_div0       (erro_div0),
        .dbg_sel         (dbg_sel),
        .dbg_valor       (dbg_valor)
`ifdef ULA_SEQ_HI_EN
        ,
        .hi_valor        (hi_valor)
`endif
    );

    // Reference ALU: 32-bit result from zero-extended 16-bit operands.
    always_comb begin
        logic [31:0] a, b;
        a = {16'h0, ula_operando1};
        b = {16'h0, ula_operando2};
        case (ula_opcode)
            3'b000:  ula_resultado = a + b;
            3'b001:  ula_resultado = a - b;
            3'b010:  ula_resultado = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b011:  ula_resultado = a * b;
            3'b100:  ula_resultado = a & b;
            3'b101:  ula_resultado = a | b;
            3'b110:  ula_resultado = {16'h0, ~ula_operando1};
            default: ula_resultado = a ^ b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, {16'h0, dbg_valor}, {16'h0, exp});
    endtask

    task automatic preload(input logic [2:0] addr, input logic [15:0] data);
        carga_en   = 1'b1;
        carga_end  = addr;
        carga_dado = data;
        tick();
        carga_en   = 1'b0;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'h0};
    endfunction

    // Issues one instruction and returns #1 after the acceptance edge T.
    task automatic issue(input string tag, input logic [15:0] ins);
        int n = 0;
        while (!instr_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'h0, instr_ready}, 32'h1);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
    endtask

    // Runs T+1..T+3 of a write-back and checks the pulse and the written register.
    task automatic expect_wb(input string tag, input logic [2:0] rd, input logic [15:0] val);
        tick();
        tick();
        check({tag, "_early"}, {31'h0, concluido}, 32'h0);
        tick();
        check({tag, "_conc"}, {31'h0, concluido}, 32'h1);
        check({tag, "_err"}, {31'h0, erro_div0}, 32'h0);
        check({tag, "_rd"}, {29'h0, concluido_rd}, {29'h0, rd});
        check({tag, "_val"}, {16'h0, concluido_valor}, {16'h0, val});
        check({tag, "_rdy"}, {31'h0, instr_ready}, 32'h1);
        check_reg({tag, "_reg"}, rd, val);
        tick();
        check({tag, "_pulse_end"}, {31'h0, concluido}, 32'h0);
    endtask

    initial begin
        int acc_n;
        int acc_at [3];

        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        carga_en    = 1'b0;
        carga_end   = '0;
        carga_dado  = '0;
        dbg_sel     = '0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        check("rst_ready", {31'h0, instr_ready}, 32'h1);
        check("rst_conc", {31'h0, concluido}, 32'h0);
        check("rst_err", {31'h0, erro_div0}, 32'h0);
        check("rst_crd", {29'h0, concluido_rd}, 32'h0);
        check("rst_cval", {16'h0, concluido_valor}, 32'h0);
        check("rst_op1", {16'h0, ula_operando1}, 32'h0);
        check("rst_op2", {16'h0, ula_operando2}, 32'h0);
        check("rst_opc", {29'h0, ula_opcode}, 32'h0);
        check_reg("rst_r5", 3'd5, 16'h0);
`ifdef ULA_SEQ_HI_EN
        check("rst_hi", {16'h0, hi_valor}, 32'h0);
`endif

        // add: R1=5, R2=3 -> R3=8
        preload(3'd1, 16'd5);
        check_reg("preload_r1", 3'd1, 16'd5);
        preload(3'd2, 16'd3);
        issue("add", mk(3'b000, 3'd3, 3'd1, 3'd2));
        check("add_busy", {31'h0, instr_ready}, 32'h0);
        tick();
        check("add_op1", {16'h0, ula_operando1}, 32'd5);
        check("add_op2", {16'h0, ula_operando2}, 32'd3);
        check("add_opc", {29'h0, ula_opcode}, 32'd0);
        tick();
        check("add_early", {31'h0, concluido}, 32'h0);
        tick();
        check("add_conc", {31'h0, concluido}, 32'h1);
        check("add_rd", {29'h0, concluido_rd}, 32'd3);
        check("add_val", {16'h0, concluido_valor}, 32'd8);
        check_reg("add_r3", 3'd3, 16'd8);
        tick();
        check("add_pulse_end", {31'h0, concluido}, 32'h0);

        // sub with borrow, preload in the same cycle as acceptance
        preload(3'd1, 16'd3);
        carga_en   = 1'b1;
        carga_end  = 3'd2;
        carga_dado = 16'd5;
        issue("sub", mk(3'b001, 3'd4, 3'd1, 3'd2));
        carga_en   = 1'b0;
        expect_wb("sub", 3'd4, 16'hFFFE);

        // mul: upper half only reaches HI
        preload(3'd5, 16'h0100);
        preload(3'd6, 16'h0300);
        issue("mul", mk(3'b011, 3'd7, 3'd5, 3'd6));
        expect_wb("mul", 3'd7, 16'h0000);
`ifdef ULA_SEQ_HI_EN
        check("mul_hi", {16'h0, hi_valor}, 32'h0003);
`endif

        // divide by zero: error pulse, R4 keeps 0xFFFE
        preload(3'd1, 16'd9);
        preload(3'd2, 16'd0);
        issue("div0", mk(3'b010, 3'd4, 3'd1, 3'd2));
        tick();
        tick();
        tick();
        check("div0_err", {31'h0, erro_div0}, 32'h1);
        check("div0_conc", {31'h0, concluido}, 32'h0);
        check_reg("div0_r4", 3'd4, 16'hFFFE);
        tick();
        check("div0_pulse_end", {31'h0, erro_div0}, 32'h0);

        // not rs1: ~9
        issue("not", mk(3'b110, 3'd5, 3'd1, 3'd0));
        expect_wb("not", 3'd5, 16'hFFF6);

        // rd == rs1: R1 = 9 ^ 8
        issue("xor", mk(3'b111, 3'd1, 3'd1, 3'd3));
        expect_wb("xor", 3'd1, 16'h0001);

        // back-to-back with valid held; preload attempt during EXEC is ignored
        acc_n       = 0;
        instr_valid = 1'b1;
        instr       = mk(3'b000, 3'd0, 3'd3, 3'd3);
        for (int c = 0; c < 9; c++) begin
            if (c == 2) begin
                carga_en   = 1'b1;
                carga_end  = 3'd2;
                carga_dado = 16'hBEEF;
            end else begin
                carga_en = 1'b0;
            end
            if (instr_ready && acc_n < 3) begin
                acc_at[acc_n] = c;
                acc_n++;
            end
            tick();
        end
        instr_valid = 1'b0;
        carga_en    = 1'b0;
        check("b2b_count", acc_n, 3);
        check("b2b_gap1", acc_at[1] - acc_at[0], 4);
        check("b2b_gap2", acc_at[2] - acc_at[1], 4);
        tick();
        tick();
        tick();
        tick();
        check_reg("b2b_r0", 3'd0, 16'd16);
        check_reg("exec_preload_ignored", 3'd2, 16'd0);

        // reset during EXEC abandons the operation
        issue("rst_mid", mk(3'b000, 3'd6, 3'd3, 3'd3));
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("rstm_ready", {31'h0, instr_ready}, 32'h1);
        check("rstm_conc", {31'h0, concluido}, 32'h0);
        check("rstm_err", {31'h0, erro_div0}, 32'h0);
        check("rstm_op1", {16'h0, ula_operando1}, 32'h0);
        check("rstm_crd", {29'h0, concluido_rd}, 32'h0);
        check_reg("rstm_r3", 3'd3, 16'h0);
        check_reg("rstm_r6", 3'd6, 16'h0);
        tick();
        tick();
        check("rstm_no_pulse", {31'h0, concluido}, 32'h0);
        check_reg("rstm_r6_late", 3'd6, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
